wb_stage: RTL

- Writeback stage sitting directly downstream of the ALU stage. It consumes the ALU's two-phase handshake outputs (three data words, CPSR image, write flag) and requests each next result by toggling the trigger.
- It commits results to the register bank write port (toggle request, ready acknowledge), and updates CPSR and PC.
- Single-clock design; all asynchronous handshake inputs are synchronized internally.

---
 rtl/wb_stage.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Writeback stage: takes ALU results over a toggle/ready handshake, writes up to two
// registers through a toggle/ack register-bank port, then commits CPSR, PC and the retire count.
module wb_stage #(
    parameter int SYNC_STAGES = 2,
    parameter int RB_TIMEOUT  = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      dataIn1,
    input  logic [31:0]      dataIn2,
    input  logic [31:0]      dataIn3,
    input  logic [31:0]      cpsrIn,
    input  logic             w,
    input  logic             readyIn,
    output logic             triggerOut,
    output logic [31:0]      dataOutRB,
    output logic [3:0]       addrRB,
    output logic             triggerOutRB,
    input  logic             readyInRB,
    output logic [31:0]      cpsrOut,
    output logic             cpsrWe,
    output logic [31:0]      pcOut,
    output logic             pcWe,
    output logic [CNT_W-1:0] retired,
    output logic             error
);

    localparam int TW = $clog2(RB_TIMEOUT + 1) + 1;

    typedef enum logic [2:0] {
        REQ, WAIT, WR1, WR1_ACK, WR2, WR2_ACK, COMMIT
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] rdy_sync_q, rb_sync_q;
    logic                   rdy_prev_q, rb_prev_q;
    logic                   pending_q, pending_d;
    logic                   rdy_rise_s, rb_rise_s, capture_s, to_hit_s, enter_commit_s;
    logic [TW-1:0]          wcnt_q;
    logic [31:0]            d1_q, d2_q, cpsr_q;
    logic [9:0]             desc_q;
    logic                   w_q;
    logic                   trig_q, rb_trig_q, cpsr_we_q, pc_we_q, error_q;
    logic [31:0]            data_q, cpsr_out_q, pc_out_q;
    logic [3:0]             addr_q;
    logic [CNT_W-1:0]       retired_q;
    logic                   unused_s;

    assign unused_s = ^dataIn3[31:10];

    assign rdy_rise_s = rdy_sync_q[SYNC_STAGES-1] & ~rdy_prev_q;
    assign rb_rise_s  = rb_sync_q[SYNC_STAGES-1] & ~rb_prev_q;
    assign capture_s  = (state_q == WAIT) & pending_q;
    assign to_hit_s   = (wcnt_q == TW'(RB_TIMEOUT));

    // A new rise always wins so a result arriving during capture is not dropped
    always_comb begin
        pending_d      = rdy_rise_s | (pending_q & ~capture_s);
        enter_commit_s = 1'b0;
        if (state_q == WR2) begin
            enter_commit_s = ~desc_q[8];
        end else if (state_q == WR2_ACK) begin
            enter_commit_s = rb_rise_s | to_hit_s;
        end else begin
            enter_commit_s = 1'b0;
        end
    end

    // Handshake synchronizers, rise-detect history and the pending-result flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_sync_q <= '0;
            rb_sync_q  <= '0;
            rdy_prev_q <= 1'b0;
            rb_prev_q  <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            rdy_sync_q <= {rdy_sync_q[SYNC_STAGES-2:0], readyIn};
            rb_sync_q  <= {rb_sync_q[SYNC_STAGES-2:0], readyInRB};
            rdy_prev_q <= rdy_sync_q[SYNC_STAGES-1];
            rb_prev_q  <= rb_sync_q[SYNC_STAGES-1];
            pending_q  <= pending_d;
        end
    end

    // Sequencer with registered handshake, write-port and commit outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= REQ;
            wcnt_q     <= '0;
            d1_q       <= 32'h0;
            d2_q       <= 32'h0;
            cpsr_q     <= 32'h0;
            desc_q     <= 10'h0;
            w_q        <= 1'b0;
            trig_q     <= 1'b0;
            rb_trig_q  <= 1'b0;
            data_q     <= 32'h0;
            addr_q     <= 4'h0;
            cpsr_out_q <= 32'h0;
            cpsr_we_q  <= 1'b0;
            pc_out_q   <= 32'h0;
            pc_we_q    <= 1'b0;
            retired_q  <= '0;
            error_q    <= 1'b0;
        end else begin
            // Strobes and commit data land on the edge into COMMIT so they span that cycle
            cpsr_we_q <= enter_commit_s & desc_q[9];
            pc_we_q   <= enter_commit_s & w_q & (desc_q[3:0] == 4'hF);
            if (enter_commit_s) begin
                retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (desc_q[9]) begin
                    cpsr_out_q <= cpsr_q;
                end
                if (w_q && (desc_q[3:0] == 4'hF)) begin
                    pc_out_q <= d1_q;
                end
            end
            case (state_q)
                REQ: begin
                    trig_q  <= ~trig_q;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (pending_q) begin
                        d1_q    <= dataIn1;
                        d2_q    <= dataIn2;
                        desc_q  <= dataIn3[9:0];
                        cpsr_q  <= cpsrIn;
                        w_q     <= w;
                        state_q <= WR1;
                    end
                end
                WR1: begin
                    if (w_q) begin
                        addr_q    <= desc_q[3:0];
                        data_q    <= d1_q;
                        rb_trig_q <= ~rb_trig_q;
                        wcnt_q    <= '0;
                        state_q   <= WR1_ACK;
                    end else begin
                        state_q <= WR2;
                    end
                end
                WR1_ACK: begin
                    if (rb_rise_s) begin
                        state_q <= WR2;
                    end else if (to_hit_s) begin
                        error_q <= 1'b1;
                        state_q <= WR2;
                    end else begin
                        wcnt_q <= wcnt_q + TW'(1);
                    end
                end
                WR2: begin
                    if (desc_q[8]) begin
                        addr_q    <= desc_q[7:4];
                        data_q    <= d2_q;
                        rb_trig_q <= ~rb_trig_q;
                        wcnt_q    <= '0;
                        state_q   <= WR2_ACK;
                    end else begin
                        state_q <= COMMIT;
                    end
                end
                WR2_ACK: begin
                    if (rb_rise_s) begin
                        state_q <= COMMIT;
                    end else if (to_hit_s) begin
                        error_q <= 1'b1;
                        state_q <= COMMIT;
                    end else begin
                        wcnt_q <= wcnt_q + TW'(1);
                    end
                end
                COMMIT: begin
                    state_q <= REQ;
                end
                default: begin
                    state_q <= REQ;
                end
            endcase
        end
    end

    assign triggerOut   = trig_q;
    assign triggerOutRB = rb_trig_q;
    assign dataOutRB    = data_q;
    assign addrRB       = addr_q;
    assign cpsrOut      = cpsr_out_q;
    assign cpsrWe       = cpsr_we_q;
    assign pcOut        = pc_out_q;
    assign pcWe         = pc_we_q;
    assign retired      = retired_q;
    assign error        = error_q;

endmodule
